// File: rtl/div3_serial_ctrl.sv
// div3_serial_ctrl: round-robin two-requester sequencer feeding a bit-serial MSB-first mod-3 residue tracker
module div3_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             owner,
   output logic [1:0]       residue,
   output logic             div_ok
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;
   logic [1:0]       r, rn;
   logic [2:0]       t;
   logic             last, cur_owner, win;
   always_comb begin
      t   = {r, 1'b0} + {2'b00, sh[WIDTH-1]};
      rn  = t >= 3'd3 ? 2'(t - 3'd3) : t[1:0];
      win = req1 & (~req0 | ~last);
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done      <= 1'b0;
         owner     <= 1'b0;
         residue   <= 2'd0;
         div_ok    <= 1'b0;
         last      <= 1'b1;
         cur_owner <= 1'b0;
         r         <= 2'd0;
         cnt       <= '0;
         sh        <= '0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (req0 | req1) begin
               sh        <= win ? data1 : data0;
               cnt       <= CW'(WIDTH);
               r         <= 2'd0;
               cur_owner <= win;
               last      <= win;
               gnt0      <= ~win;
               gnt1      <= win;
               state     <= SHIFT;
            end
            SHIFT: begin
               r   <= rn;
               sh  <= {sh[WIDTH-2:0], 1'b0};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  residue <= rn;
                  div_ok  <= rn == 2'd0;
                  owner   <= cur_owner;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
